// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between the PC stage and the decoder.
// Walks a private fetch address, issues one-word req/ack reads to instruction
// memory and buffers returned words with their addresses in a DEPTH-entry FIFO.
// A flush discards queued and in-flight words and restarts fetch at flush_pc.
// Optional build macro IFQ_BYPASS_EN: when the FIFO is empty, an acked word is
// presented on ins_* in the same cycle (and skips the FIFO if consumed).
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        boot,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   addr_q, addr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_after_pop;

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          fifo_nonempty;
  logic          acked_word;
  logic          bypass_valid;
  logic          bypass_take;
  logic          fifo_pop;
  logic          push;
  logic [31:0]   start_pc;

  assign start_pc      = boot ? 32'd3 : 32'd0;
  assign fifo_nonempty = (count_q != '0);
  // A word returned for a live (non-flushed) request.
  assign acked_word    = (state_q == S_WAIT) && mem_ack && !flush;

`ifdef IFQ_BYPASS_EN
  assign bypass_valid  = acked_word && !fifo_nonempty;
  assign bypass_take   = bypass_valid && ins_ready;
`else
  assign bypass_valid  = 1'b0;
  assign bypass_take   = 1'b0;
`endif

  // Flush wins over both pop and push in the same cycle.
  assign fifo_pop        = fifo_nonempty && ins_ready && !flush;
  assign push            = acked_word && !bypass_take;
  assign count_after_pop = count_q - CW'(fifo_pop);

  assign mem_req   = (state_q != S_IDLE);
  assign mem_addr  = addr_q;
  assign ins_valid = fifo_nonempty || bypass_valid;
  assign ins_pc    = fifo_nonempty ? pc_mem[rd_ptr_q]
                   : (bypass_valid ? addr_q : 32'd0);
  assign ins_data  = fifo_nonempty ? data_mem[rd_ptr_q]
                   : (bypass_valid ? mem_rdata : 32'd0);

  // Next-state logic for the fetch FSM, fetch address and FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    addr_d   = addr_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (fifo_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push)     wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_after_pop + CW'(push);
    end

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          fpc_d = flush_pc;
        end else if (count_after_pop < DEPTH_C) begin
          addr_d  = fpc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          fpc_d   = flush_pc;
          state_d = mem_ack ? S_IDLE : S_DROP;
        end else if (mem_ack) begin
          fpc_d = addr_q + 32'd1;
          // Back-to-back request only while the FIFO still has room for it.
          if (count_d < DEPTH_C) begin
            addr_d = addr_q + 32'd1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        // The stale request stays up until memory answers it.
        if (flush)   fpc_d   = flush_pc;
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset loads the boot-selected start address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      fpc_q    <= start_pc;
      addr_q   <= start_pc;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; head is read combinationally.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= addr_q;
      data_mem[wr_ptr_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue (DEPTH=4). A behavioural memory returns
// data = addr + 0x100. Expected {pc,data} pairs are queued when the memory acks
// a live request and compared in order when the decoder side consumes a word.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        boot = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_ready = 1'b0;

  logic        ack_always = 1'b0;
  logic        ack_now = 1'b0;

  int          vectors = 0;
  int          miscompares = 0;
  int          ack_count = 0;
  logic [31:0] exp_fetch = 32'd0;
  bit          sb_capture = 1'b0;
  logic [63:0] sb_q [$];

  always #5 clk = ~clk;

  assign mem_ack   = mem_req && (ack_always || ack_now);
  assign mem_rdata = mem_addr + 32'h100;

  ifetch_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .boot      (boot),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ins_valid (ins_valid),
    .ins_data  (ins_data),
    .ins_pc    (ins_pc),
    .ins_ready (ins_ready)
  );

  // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    logic [63:0] exp_word;
    @(negedge clk);
    if (mem_req && mem_ack) begin
      ack_count++;
      if (sb_capture) begin
        vectors++;
        if (mem_addr !== exp_fetch) begin
          miscompares++;
          $display("FAIL fetch_addr: got %h expected %h", mem_addr, exp_fetch);
        end
        sb_q.push_back({exp_fetch, exp_fetch + 32'h100});
        exp_fetch = exp_fetch + 32'd1;
      end
    end
    if (ins_valid && ins_ready && !flush) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_word: got pc %h data %h, expected no word", ins_pc, ins_data);
      end else begin
        exp_word = sb_q.pop_front();
        $display("pop pc=%h data=%h", ins_pc, ins_data);
        if ({ins_pc, ins_data} !== exp_word) begin
          miscompares++;
          $display("FAIL word: got pc %h data %h expected pc %h data %h",
                   ins_pc, ins_data, exp_word[63:32], exp_word[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    boot = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    vectors++;
    if ({mem_req, ins_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_req_valid: got %b%b expected 00", mem_req, ins_valid);
    end
    vectors++;
    if (mem_addr !== 32'd3) begin
      miscompares++;
      $display("FAIL reset_addr: got %h expected 00000003", mem_addr);
    end
    vectors++;
    if ({ins_pc, ins_data} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_ins: got pc %h data %h expected 0 0", ins_pc, ins_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd3) begin
      miscompares++;
      $display("FAIL first_req: got req %b addr %h expected 1 00000003", mem_req, mem_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    exp_fetch  = 32'd3;
    sb_capture = 1'b1;
    ack_count  = 0;
    ack_always = 1'b1;
    ins_ready  = 1'b1;
`ifdef IFQ_BYPASS_EN
    vectors++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'd3 || ins_data !== 32'h103) begin
      miscompares++;
      $display("FAIL bypass_first: got v %b pc %h data %h expected 1 3 103", ins_valid, ins_pc, ins_data);
    end
    tick();
`else
    tick();
    vectors++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'd3 || ins_data !== 32'h103) begin
      miscompares++;
      $display("FAIL first_word_latency: got v %b pc %h data %h expected 1 3 103", ins_valid, ins_pc, ins_data);
    end
`endif
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (ack_count !== 9) begin
      miscompares++;
      $display("FAIL throughput: got %0d acks expected 9", ack_count);
    end
    ack_always = 1'b0;
    tick();
    tick();
    $display("test_stream done");
  endtask

  task automatic test_fill();
    ins_ready  = 1'b0;
    ack_count  = 0;
    ack_always = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    vectors++;
    if (ack_count !== 4 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_stop: got %0d acks req %b expected 4 0", ack_count, mem_req);
    end
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd16) begin
      miscompares++;
      $display("FAIL refill_req: got req %b addr %h expected 1 00000010", mem_req, mem_addr);
    end
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (ack_count !== 5 || mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL refill_once: got %0d acks req %b expected 5 0", ack_count, mem_req);
    end
    ack_always = 1'b0;
    ins_ready  = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    $display("test_fill done");
  endtask

  task automatic test_flush_drop();
    flush      = 1'b1;
    flush_pc   = 32'h40;
    sb_capture = 1'b0;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 32'd17 || ins_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_hold: got req %b addr %h v %b expected 1 00000011 0", mem_req, mem_addr, ins_valid);
      end
      tick();
    end
    ack_now = 1'b1;
    tick();
    ack_now = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_discard: got req %b v %b expected 0 0", mem_req, ins_valid);
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_target_req: got req %b addr %h v %b expected 1 00000040 0", mem_req, mem_addr, ins_valid);
    end
    exp_fetch  = 32'h40;
    sb_capture = 1'b1;
    ack_now    = 1'b1;
    tick();
    ack_now = 1'b0;
    tick();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL flush_target_word: got %0d undelivered expected 0", sb_q.size());
    end
    $display("test_flush_drop done");
  endtask

  task automatic test_flush_ack();
    flush      = 1'b1;
    flush_pc   = 32'd2;
    ack_now    = 1'b1;
    sb_capture = 1'b0;
    tick();
    flush   = 1'b0;
    ack_now = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ack_idle: got req %b v %b expected 0 0", mem_req, ins_valid);
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd2) begin
      miscompares++;
      $display("FAIL vector_req: got req %b addr %h expected 1 00000002", mem_req, mem_addr);
    end
    exp_fetch  = 32'd2;
    sb_capture = 1'b1;
    ack_always = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ack_always = 1'b0;
    tick();
    tick();
    $display("test_flush_ack done");
  endtask

  task automatic test_wrap();
    flush      = 1'b1;
    flush_pc   = 32'hFFFF_FFFF;
    ack_now    = 1'b1;
    sb_capture = 1'b0;
    tick();
    flush   = 1'b0;
    ack_now = 1'b0;
    tick();
    vectors++;
    if (mem_addr !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_req: got %h expected ffffffff", mem_addr);
    end
    exp_fetch  = 32'hFFFF_FFFF;
    sb_capture = 1'b1;
    ack_always = 1'b1;
`ifdef IFQ_BYPASS_EN
    vectors++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_bypass: got v %b pc %h expected 1 ffffffff", ins_valid, ins_pc);
    end
`else
    vectors++;
    if (ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_comb_path: got v %b expected 0", ins_valid);
    end
`endif
    for (int i = 0; i < 3; i++) tick();
    ack_always = 1'b0;
    tick();
    tick();
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    ins_ready  = 1'b0;
    ack_always = 1'b1;
    tick();
    tick();
    ack_always = 1'b0;
    vectors++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'd2) begin
      miscompares++;
      $display("FAIL pre_reset_queue: got v %b pc %h expected 1 00000002", ins_valid, ins_pc);
    end
    boot  = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || ins_valid !== 1'b0 || mem_addr !== 32'd0 || ins_pc !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: got req %b v %b addr %h pc %h expected 0 0 0 0", mem_req, ins_valid, mem_addr, ins_pc);
    end
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL restart_req: got req %b addr %h expected 1 00000000", mem_req, mem_addr);
    end
    exp_fetch  = 32'd0;
    sb_capture = 1'b1;
    ack_always = 1'b1;
    ins_ready  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    ack_always = 1'b0;
    tick();
    tick();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL restart_words: got %0d undelivered expected 0", sb_q.size());
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_flush_drop();
    test_flush_ack();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction prefetch queue between the program counter stage and the decoder. It walks a private fetch address and issues one-word requests to instruction memory over a req/ack handshake, then buffers the returned words with their addresses in a small FIFO. The decoder pops the FIFO through a valid/ready handshake. Control flow changes (jump, branch, call, ret, interrupt) arrive as a `flush` with a new target; the queue discards stale state and refetches from that target.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `boot  in  1`: reset start address select; 1 → 32'd3, 0 → 32'd0. Sampled while `rst_n`=0.
- `flush  in  1`: redirect request, single-cycle pulse.
- `flush_pc  in  32`: redirect target; valid when `flush`=1.
- `mem_req  out  1`: instruction memory read request.
- `mem_addr  out  32`: word address of the request.
- `mem_ack  in  1`: memory returns data this cycle.
- `mem_rdata  in  32`: instruction word; valid when `mem_ack`=1.
- `ins_valid  out  1`: FIFO head is valid.
- `ins_data  out  32`: head instruction word.
- `ins_pc  out  32`: address of the head instruction.
- `ins_ready  in  1`: decoder accepts the head this cycle.

## Operation
- Registers:
  - `fpc[31:0]`: next fetch address.
  - FIFO: `DEPTH` × {pc, data}, with read pointer, write pointer, and `count[$clog2(DEPTH):0]`.
  - `state`: IDLE, WAIT, or DROP.
- Addresses are word addresses. The fetch address advances by `fpc+1` and wraps at 32'hFFFF_FFFF → 0.
- `mem_req` = (state==WAIT or state==DROP). `mem_addr` = the captured request address. Once `mem_req` rises, it and `mem_addr` stay stable until `mem_ack`. There is at most one outstanding request.
- IDLE:
  - If `flush`, load `fpc`←`flush_pc` and stay in IDLE.
  - Else, if `count` (after any pop this cycle) < `DEPTH`, capture `mem_addr`←`fpc` and go to WAIT.
- WAIT:
  - On `mem_ack` without `flush`: push {`mem_addr`, `mem_rdata`}, set `fpc`←`mem_addr+1`. If space remains, issue the next request immediately (stay in WAIT, `mem_addr`←`mem_addr+1`); otherwise go to IDLE.
  - On `flush` with `mem_ack`: discard the data, `fpc`←`flush_pc`, go to IDLE.
  - On `flush` without `mem_ack`: `fpc`←`flush_pc`, go to DROP.
- DROP:
  - Keeps the old request up until `mem_ack`, then discards the data and goes to IDLE.
  - A further `flush` in DROP only reloads `fpc`.
- Pop: on `ins_valid && ins_ready`, the read pointer advances.
- `flush` clears the FIFO (`count`←0) in the same edge and overrides any pop or push that cycle.
- A push and a pop in the same cycle leave `count` unchanged.
- A push never occurs when full, because a request is issued only when space is guaranteed.
- `ins_valid` = `count`≠0. `ins_data`/`ins_pc` come from the head entry and read 0 when empty.

## Timing
- Reset values:
  - `state`=IDLE, `count`=0, `mem_req`=0.
  - `mem_addr`=`fpc`=(`boot` ? 3 : 0).
  - `ins_valid`=0, `ins_data`=0, `ins_pc`=0.
- First clock edge after reset release: `mem_req`=1 with the start address.
- Fetch-to-decode latency without bypass: data is visible on `ins_*` the cycle after the `mem_ack` edge.
- Throughput: one word per cycle when `mem_ack` is asserted combinationally in the request cycle and the FIFO is not full.
- After `flush` at edge N: `ins_valid`=0 from N. The first request for `flush_pc` is issued at edge N+1 (state was IDLE/WAIT) or one cycle after the DROP ack.
- `rst_n` asserted mid-request drops `mem_req` asynchronously. Memory must tolerate an abandoned request.

## Configuration
- `IFQ_BYPASS_EN` defined:
  - When the FIFO is empty and `mem_ack` arrives in WAIT without `flush`, `ins_valid`/`ins_data`/`ins_pc` present `mem_rdata`/`mem_addr` combinationally in the same cycle.
  - If `ins_ready`=1 that cycle, the word is consumed and not written. Otherwise it is pushed normally.
- Undefined: there is no combinational path from `mem_*` to `ins_*`. Latency is as in Timing.

## Test plan
- Reset with `boot`=1, memory acks every cycle with data=addr+0x100, `ins_ready`=1 → `mem_addr` 3,4,5…; `ins_pc`=3 with `ins_data`=0x103 one cycle after the first ack.
- `ins_ready`=0 and `DEPTH`=4 → exactly 4 acks accepted, `mem_req` stays 0 after that. Pop one → exactly one new request, `mem_addr`=start+4.
- `flush` with `flush_pc`=0x40 while WAIT, ack delayed 3 cycles → DROP holds the old address, the acked data is discarded, the next request is 0x40, and `ins_valid` stays 0 until 0x40's data arrives.
- `flush` and `mem_ack` in the same cycle with `flush_pc`=2 (interrupt vector) → that data is never seen; the next request is 2 one cycle later.
- `fpc`=0xFFFF_FFFF → `ins_pc` sequence is 0xFFFF_FFFF, then 0. With `IFQ_BYPASS_EN` and an empty FIFO, `ins_valid`=1 in the ack cycle.
- `rst_n` pulsed low mid-WAIT with 2 entries queued → `count`=0, `mem_req`=0, `ins_valid`=0 immediately; fetch restarts at 0 with `boot`=0.
